// File: rtl/p_mul_issue.sv
// Issue/retire stage in front of the packed multiplier p_mul: accepts requests, holds the
// multiplier valid level for the whole operation, and buffers the response for writeback.
// Optional feature: `P_MUL_ISSUE_ZERO_SKIP_EN completes requests with a zero operand without the multiplier.
module p_mul_issue #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_mul_l,
    input  logic             req_mul_h,
    input  logic             req_clmul,
    input  logic [4:0]       req_pw,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,

    output logic             mul_valid,
    input  logic             mul_ready,
    output logic             mul_mul_l,
    output logic             mul_mul_h,
    output logic             mul_clmul,
    output logic [4:0]       mul_pw,
    output logic [31:0]      mul_crs1,
    output logic [31:0]      mul_crs2,
    input  logic [31:0]      mul_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned PW_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t accept_state;

    logic             accept;
    logic             req_bad;
    logic             req_skip;
    logic             pw_ok;
    logic             op_ok;

    logic             mul_valid_nxt;
    logic             mul_mul_l_nxt;
    logic             mul_mul_h_nxt;
    logic             mul_clmul_nxt;
    logic [PW_W-1:0]  mul_pw_nxt;
    logic [XLEN-1:0]  mul_crs1_nxt;
    logic [XLEN-1:0]  mul_crs2_nxt;
    logic             rsp_valid_nxt;
    logic [XLEN-1:0]  rsp_result_nxt;
    logic             rsp_err_nxt;
    logic [TAG_W-1:0] rsp_tag_nxt;

    // Pack width 2 is not supported by the multiplier, so only 32/16/8/4 are legal.
    assign pw_ok   = (req_pw == 5'b00001) || (req_pw == 5'b00010)
                  || (req_pw == 5'b00100) || (req_pw == 5'b01000);
    assign op_ok   = $onehot({req_mul_l, req_mul_h, req_clmul});
    assign req_bad = !(pw_ok && op_ok);

`ifdef P_MUL_ISSUE_ZERO_SKIP_EN
    assign req_skip = !req_bad && ((req_rs1 == '0) || (req_rs2 == '0));
`else
    assign req_skip = 1'b0;
`endif

    // A slot opens when idle or when the held response drains this cycle.
    assign req_ready = resetn && !flush
                    && ((state == IDLE) || ((state == DONE) && rsp_ready));
    assign accept       = req_valid && req_ready;
    assign accept_state = (req_bad || req_skip) ? DONE : BUSY;

    // State and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            mul_valid  <= 1'b0;
            mul_mul_l  <= 1'b0;
            mul_mul_h  <= 1'b0;
            mul_clmul  <= 1'b0;
            mul_pw     <= '0;
            mul_crs1   <= '0;
            mul_crs2   <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_tag    <= '0;
        end else begin
            state      <= state_nxt;
            mul_valid  <= mul_valid_nxt;
            mul_mul_l  <= mul_mul_l_nxt;
            mul_mul_h  <= mul_mul_h_nxt;
            mul_clmul  <= mul_clmul_nxt;
            mul_pw     <= mul_pw_nxt;
            mul_crs1   <= mul_crs1_nxt;
            mul_crs2   <= mul_crs2_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_result <= rsp_result_nxt;
            rsp_err    <= rsp_err_nxt;
            rsp_tag    <= rsp_tag_nxt;
        end
    end

    // Next-state logic; flush wins over every handshake
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state_nxt = accept_state;
                end
                BUSY: begin
                    if (mul_ready) state_nxt = DONE;
                end
                DONE: begin
                    if (rsp_ready) state_nxt = accept ? accept_state : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        mul_valid_nxt  = mul_valid;
        mul_mul_l_nxt  = mul_mul_l;
        mul_mul_h_nxt  = mul_mul_h;
        mul_clmul_nxt  = mul_clmul;
        mul_pw_nxt     = mul_pw;
        mul_crs1_nxt   = mul_crs1;
        mul_crs2_nxt   = mul_crs2;
        rsp_valid_nxt  = rsp_valid;
        rsp_result_nxt = rsp_result;
        rsp_err_nxt    = rsp_err;
        rsp_tag_nxt    = rsp_tag;

        if (flush) begin
            mul_valid_nxt = 1'b0;
            rsp_valid_nxt = 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    // Dropping valid after the finish pulse lets the multiplier rewind its count.
                    if (mul_ready) begin
                        mul_valid_nxt  = 1'b0;
                        rsp_valid_nxt  = 1'b1;
                        rsp_result_nxt = mul_result;
                        rsp_err_nxt    = 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready) rsp_valid_nxt = 1'b0;
                end
                default: ;
            endcase

            if (accept) begin
                mul_mul_l_nxt = req_mul_l;
                mul_mul_h_nxt = req_mul_h;
                mul_clmul_nxt = req_clmul;
                mul_pw_nxt    = req_pw;
                mul_crs1_nxt  = req_rs1;
                mul_crs2_nxt  = req_rs2;
                rsp_tag_nxt   = req_tag;
                if (req_bad) begin
                    mul_valid_nxt  = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_err_nxt    = 1'b1;
                    rsp_result_nxt = '0;
                end else if (req_skip) begin
                    mul_valid_nxt  = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    rsp_err_nxt    = 1'b0;
                    rsp_result_nxt = '0;
                end else begin
                    mul_valid_nxt  = 1'b1;
                    rsp_valid_nxt  = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_p_mul_issue.sv
// Scoreboard bench for p_mul_issue with a behavioural packed-multiplier model on the mul_* side.
module tb_p_mul_issue;

    localparam int unsigned TAG_W = 5;

    logic             clock = 1'b0;
    logic             resetn;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic             req_mul_l, req_mul_h, req_clmul;
    logic [4:0]       req_pw;
    logic [31:0]      req_rs1, req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             mul_valid;
    logic             mul_ready;
    logic             mul_mul_l, mul_mul_h, mul_clmul;
    logic [4:0]       mul_pw;
    logic [31:0]      mul_crs1, mul_crs2;
    logic [31:0]      mul_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    always #5 clock = ~clock;

    p_mul_issue #(.TAG_W(TAG_W)) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mul_l(req_mul_l), .req_mul_h(req_mul_h), .req_clmul(req_clmul),
        .req_pw(req_pw), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .mul_valid(mul_valid), .mul_ready(mul_ready),
        .mul_mul_l(mul_mul_l), .mul_mul_h(mul_mul_h), .mul_clmul(mul_clmul),
        .mul_pw(mul_pw), .mul_crs1(mul_crs1), .mul_crs2(mul_crs2), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mcnt = 0;
    int mv_cycles = 0;
    int mv0;
    int n;

    typedef struct {
        logic [31:0]      result;
        logic             err;
        logic [TAG_W-1:0] tag;
        int               acc;
        int               lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   lat_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pw_cycles(input logic [4:0] pw);
        return pw[0] ? 32 : pw[1] ? 16 : pw[2] ? 8 : 4;
    endfunction

    function automatic logic [31:0] pmul(input logic l, input logic h, input logic c,
                                         input logic [4:0] pw, input logic [31:0] a,
                                         input logic [31:0] b);
        int          w;
        logic [63:0] mask, x, y, p;
        logic [31:0] r;
        w    = pw_cycles(pw);
        mask = (64'd1 << w) - 64'd1;
        r    = '0;
        for (int i = 0; i < 32 / w; i++) begin
            x = (64'(a) >> (i * w)) & mask;
            y = (64'(b) >> (i * w)) & mask;
            if (c) begin
                p = '0;
                for (int k = 0; k < w; k++) if (y[k]) p = p ^ (x << k);
            end else begin
                p = x * y;
            end
            if (h && !l) p = p >> w;
            r = r | 32'((p & mask) << (i * w));
        end
        return r;
    endfunction

    function automatic bit is_bad(input logic l, input logic h, input logic c, input logic [4:0] pw);
        bit pw_ok;
        pw_ok = (pw == 5'd1) || (pw == 5'd2) || (pw == 5'd4) || (pw == 5'd8);
        return !pw_ok || ((int'(l) + int'(h) + int'(c)) != 1);
    endfunction

    function automatic int exp_lat(input bit bad, input logic [4:0] pw,
                                   input logic [31:0] a, input logic [31:0] b);
        if (bad) return 1;
`ifdef P_MUL_ISSUE_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 1;
`endif
        if (a == 32'hFFFF_FFFF && b == 32'hFFFF_FFFF) return pw_cycles(pw) + 2;
        return pw_cycles(pw) + 2;
    endfunction

    // Multiplier model: finish pulse in the (M+1)-th cycle of valid, result from the registered operands.
    always @(posedge clock) begin
        if (mul_valid !== 1'b1 || mul_ready) mcnt <= 0;
        else                                 mcnt <= mcnt + 1;
        cyc <= cyc + 1;
    end
    assign mul_ready  = (mul_valid === 1'b1) && (mcnt == pw_cycles(mul_pw));
    assign mul_result = pmul(mul_mul_l, mul_mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2);

    // Monitor: scoreboard push on accept, latency check on first valid, pop on handshake.
    always @(negedge clock) begin
        #2;
        if (!resetn || flush) begin
            sb.delete();
            lat_done = 1'b0;
        end else begin
            if (mul_valid) mv_cycles++;
            if (sb.size() == 0) begin
                chk("no_rsp_expected", 32'(rsp_valid), 32'd0);
            end else if (rsp_valid && !lat_done) begin
                chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                lat_done = 1'b1;
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rsp_result", rsp_result, mon_e.result);
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                chk("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
                lat_done = 1'b0;
            end
            if (req_valid && req_ready) begin
                mon_e.err    = is_bad(req_mul_l, req_mul_h, req_clmul, req_pw);
                mon_e.result = mon_e.err ? 32'd0
                             : pmul(req_mul_l, req_mul_h, req_clmul, req_pw, req_rs1, req_rs2);
                mon_e.tag    = req_tag;
                mon_e.acc    = cyc;
                mon_e.lat    = exp_lat(mon_e.err, req_pw, req_rs1, req_rs2);
                sb.push_back(mon_e);
            end
        end
    end

    task automatic set_req(input logic l, input logic h, input logic c, input logic [4:0] pw,
                           input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        req_mul_l = l; req_mul_h = h; req_clmul = c;
        req_pw = pw; req_rs1 = a; req_rs2 = b; req_tag = t;
        req_valid = 1'b1;
    endtask

    task automatic issue(input logic l, input logic h, input logic c, input logic [4:0] pw,
                         input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        int k;
        @(negedge clock);
        set_req(l, h, c, pw, a, b, t);
        k = 0;
        #1;
        while (!req_ready && k < 300) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 400) begin
            @(negedge clock);
            k++;
        end
        #3;
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_mul_l = 1'b0; req_mul_h = 1'b0; req_clmul = 1'b0;
        req_pw = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;

        repeat (3) @(negedge clock);
        #1 chk("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1;
        chk("reset_mul_valid", 32'(mul_valid), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("reset_mul_ops", 32'({mul_mul_l, mul_mul_h, mul_clmul, mul_pw}), 32'd0);
        chk("reset_mul_crs", mul_crs1 | mul_crs2, 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        issue(1'b1, 1'b0, 1'b0, 5'b00001, 32'h0000_1234, 32'h0000_0010, 5'd5);
        wait_idle();

        mv0 = mv_cycles;
        issue(1'b1, 1'b0, 1'b0, 5'b00100, 32'h0203_0405, 32'h0202_0202, 5'd3);
        wait_idle();
        chk("pw8_mul_valid_cycles", 32'(mv_cycles - mv0), 32'd9);

        mv0 = mv_cycles;
        issue(1'b1, 1'b0, 1'b0, 5'b10000, 32'h1111_1111, 32'h2222_2222, 5'd7);
        wait_idle();
        issue(1'b1, 1'b1, 1'b0, 5'b00001, 32'h1111_1111, 32'h2222_2222, 5'd8);
        wait_idle();
        issue(1'b0, 1'b0, 1'b0, 5'b00010, 32'h3, 32'h4, 5'd9);
        issue(1'b0, 1'b0, 1'b1, 5'b00011, 32'h3, 32'h4, 5'd10);
        wait_idle();
        chk("malformed_mul_valid_cycles", 32'(mv_cycles - mv0), 32'd0);

        for (int i = 0; i < 8; i++) begin
            logic [4:0] pw;
            logic       cl;
            pw = 5'(1 << $urandom_range(0, 3));
            cl = 1'($urandom_range(0, 1));
            issue(!cl, 1'b0, cl, pw, $urandom | 32'h1, $urandom | 32'h100, 5'(i + 16));
        end
        wait_idle();

        // Backpressure: response held with a competing request present.
        rsp_ready = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 5'b01000, 32'h7654_3210, 32'h1111_1111, 5'd11);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!rsp_valid) chk("bp_rsp_timeout", 32'(rsp_valid), 32'd1);
        set_req(1'b1, 1'b0, 1'b0, 5'b00010, 32'h0003_0005, 32'h0007_0009, 5'd12);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_result", rsp_result, 32'h7654_3210);
            chk("bp_rsp_tag", 32'(rsp_tag), 32'd11);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        #1 chk("b2b_req_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        chk("b2b_mul_valid", 32'(mul_valid), 32'd1);
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd0);
        wait_idle();

        // Flush in the 7th BUSY cycle of a pw16 operation.
        issue(1'b1, 1'b0, 1'b0, 5'b00010, 32'h0003_0002, 32'h0005_0007, 5'd13);
        repeat (6) @(negedge clock);
        flush = 1'b1;
        #1 chk("flush_req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        flush = 1'b0;
        #1;
        chk("flush_mul_valid", 32'(mul_valid), 32'd0);
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        #2 chk("flush_sb_empty", 32'(sb.size()), 32'd0);
        repeat (20) @(negedge clock);
        issue(1'b1, 1'b0, 1'b0, 5'b00010, 32'h0010_0020, 32'h0003_0004, 5'd14);
        wait_idle();

        mv0 = mv_cycles;
        issue(1'b1, 1'b0, 1'b0, 5'b00010, 32'h0000_1234, 32'h0000_0000, 5'd15);
        wait_idle();
`ifdef P_MUL_ISSUE_ZERO_SKIP_EN
        chk("zero_mul_valid_cycles", 32'(mv_cycles - mv0), 32'd0);
`else
        chk("zero_mul_valid_cycles", 32'(mv_cycles - mv0), 32'd17);
`endif

        // Reset in the middle of an operation.
        issue(1'b1, 1'b0, 1'b0, 5'b00001, 32'h0000_DEAD, 32'h0000_BEEF, 5'd17);
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        #1 chk("midrst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("midrst_mul_valid", 32'(mul_valid), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_mul_crs1", mul_crs1, 32'd0);
        chk("midrst_rsp_tag", 32'(rsp_tag), 32'd0);
        issue(1'b0, 1'b0, 1'b1, 5'b01000, 32'h0000_00F3, 32'h0000_0075, 5'd18);
        wait_idle();

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
